// File: rtl/rvfi_sched_pkg.sv
// rvfi_sched_pkg: shared types for the RVFI step scheduler.
package rvfi_sched_pkg;
    localparam int ORDER_W = 64;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE, HALT} sched_state_e;
    // Single-field struct so trap/interrupt info can be added later without touching the FIFO.
    typedef struct packed {
        logic [ORDER_W-1:0] order;
    } sched_entry_t;
endpackage

// File: rtl/rvfi_sched_fifo.sv
// rvfi_sched_fifo: multi-push (up to NRET, compacted in lane order), single-pop FIFO.
module rvfi_sched_fifo
    import rvfi_sched_pkg::*;
#(
    parameter int NRET = 1,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [NRET-1:0]         push_mask_i,
    input  sched_entry_t [NRET-1:0] push_data_i,
    input  logic                    pop_i,
    output sched_entry_t            head_o,
    output logic [CW-1:0]           count_o
);
    localparam int AW = $clog2(DEPTH);
    sched_entry_t mem_q [DEPTH];
    sched_entry_t mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, n_push;

    always_comb begin
        mem_d = mem_q;
        n_push = '0;
        for (int k = 0; k < NRET; k++) begin
            if (push_i && push_mask_i[k]) begin
                mem_d[wr_ptr_q + AW'(n_push)] = push_data_i[k];
                n_push = n_push + CW'(1);
            end
        end
        wr_ptr_d = wr_ptr_q + AW'(n_push);
        rd_ptr_d = rd_ptr_q + AW'(pop_i);
        count_d = count_q + n_push - CW'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible while the count is zero.
    always_ff @(posedge clk_i) mem_q <= mem_d;

    assign head_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/rvfi_step_scheduler.sv
// rvfi_step_scheduler: buffers RVFI retirements, checks order continuity and
// issues ISS steps one at a time over a req/ack + done handshake.
module rvfi_step_scheduler
    import rvfi_sched_pkg::*;
#(
    parameter int NRET = 1,
    parameter int DEPTH = 16,
    parameter int TIMEOUT = 1024,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic [NRET-1:0]         ret_valid_i,
    input  logic [NRET*ORDER_W-1:0] ret_order_i,
    output logic                    step_req_o,
    output logic [ORDER_W-1:0]      step_order_o,
    input  logic                    step_ack_i,
    input  logic                    step_done_i,
    output logic [CW-1:0]           pending_o,
    output logic                    idle_o,
    output logic                    overflow_o,
    output logic                    order_err_o,
    output logic                    timeout_o
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    sched_state_e state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [ORDER_W-1:0] exp_q, exp_d;
    logic exp_vld_q, exp_vld_d, overflow_q, overflow_d;
    logic order_err_q, order_err_d, timeout_q, timeout_d;
    logic [CW-1:0] n_valid, count;
    logic push, gap, pop;
    sched_entry_t [NRET-1:0] lanes;
    sched_entry_t head;

    rvfi_sched_fifo #(.NRET(NRET), .DEPTH(DEPTH)) u_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .push_i(push), .push_mask_i(ret_valid_i),
        .push_data_i(lanes), .pop_i(pop), .head_o(head), .count_o(count)
    );

    // Free space ignores a same-cycle pop, so a group fits only if it fits now.
    always_comb begin
        n_valid = '0;
        for (int k = 0; k < NRET; k++) begin
            n_valid = n_valid + CW'(ret_valid_i[k]);
            lanes[k].order = ret_order_i[k*ORDER_W +: ORDER_W];
        end
        push = n_valid <= CW'(DEPTH) - count;
        exp_d = exp_q;
        exp_vld_d = exp_vld_q;
        gap = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            if (push && ret_valid_i[k]) begin
                gap |= exp_vld_d && (lanes[k].order != exp_d);
                exp_d = lanes[k].order + ORDER_W'(1);
                exp_vld_d = 1'b1;
            end
        end
        overflow_d = overflow_q | ~push;
        order_err_d = order_err_q | gap;
    end

    always_comb begin
        state_d = state_q;
        timeout_d = timeout_q;
        cnt_d = '0;
        case (state_q)
            IDLE: if (enable_i && count != '0) state_d = REQ;
            REQ: if (step_ack_i) state_d = WAIT_DONE;
            WAIT_DONE: begin
                cnt_d = cnt_q + TW'(1);
                if (step_done_i) state_d = (enable_i && count != '0) ? REQ : IDLE;
                else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = HALT;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = HALT;
        endcase
        if (gap) state_d = HALT;
    end

    always_comb begin
        step_req_o = state_q == REQ;
        pop = step_req_o && step_ack_i;
        step_order_o = step_req_o ? head.order : '0;
        idle_o = state_q == IDLE && count == '0;
        pending_o = count;
        overflow_o = overflow_q;
        order_err_o = order_err_q;
        timeout_o = timeout_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q <= '0;
            exp_q <= '0;
            exp_vld_q <= 1'b0;
            overflow_q <= 1'b0;
            order_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            exp_q <= exp_d;
            exp_vld_q <= exp_vld_d;
            overflow_q <= overflow_d;
            order_err_q <= order_err_d;
            timeout_q <= timeout_d;
        end
    end
endmodule

// File: tb/tb_rvfi_step_scheduler.sv
// tb_rvfi_step_scheduler: directed checks of capture, ordering, overflow, timeout and reset.
module tb_rvfi_step_scheduler;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, ack = 1'b0, done = 1'b0;
    logic [1:0] valid = '0;
    logic [127:0] order = '0;
    logic req, idle, ovf, oerr, tmo;
    logic [63:0] sorder;
    logic [2:0] pend;
    int vectors = 0, miscompares = 0;

    rvfi_step_scheduler #(.NRET(2), .DEPTH(4), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .ret_valid_i(valid), .ret_order_i(order),
        .step_req_o(req), .step_order_o(sorder), .step_ack_i(ack), .step_done_i(done),
        .pending_o(pend), .idle_o(idle), .overflow_o(ovf), .order_err_o(oerr), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [63:0] o);
        valid = 2'b01;
        order = {64'd0, o};
    endtask

    task automatic push2(input logic [63:0] o0, input logic [63:0] o1);
        valid = 2'b11;
        order = {o1, o0};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0; valid = '0; ack = 1'b0; done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #12;
        chk("rst_idle", 64'(idle), 1);
        chk("rst_req", 64'(req), 0);
        chk("rst_pend", 64'(pend), 0);
        chk("rst_flags", {61'd0, ovf, oerr, tmo}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single step
        en = 1'b1;
        push1(64'd5);
        tick();
        valid = '0;
        chk("s1_pend", 64'(pend), 1);
        chk("s1_req_pre", 64'(req), 0);
        tick();
        chk("s1_req", 64'(req), 1);
        chk("s1_order", sorder, 5);
        tick();
        chk("s1_req_hold", 64'(req), 1);
        chk("s1_order_hold", sorder, 5);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("s1_req_drop", 64'(req), 0);
        chk("s1_pend_pop", 64'(pend), 0);
        tick();
        chk("s1_busy", 64'(idle), 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("s1_idle", 64'(idle), 1);
        chk("s1_pend_end", 64'(pend), 0);

        // lane compaction
        do_reset();
        valid = 2'b10;
        order = {64'd7, 64'd0};
        tick();
        push2(64'd8, 64'd9);
        tick();
        valid = '0;
        chk("c_pend", 64'(pend), 3);
        chk("c_oerr", 64'(oerr), 0);
        en = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("c_req", 64'(req), 1);
            chk("c_order", sorder, 64'(7 + i));
            ack = 1'b1;
            tick();
            ack = 1'b0;
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        chk("c_idle", 64'(idle), 1);
        chk("c_oerr_end", 64'(oerr), 0);

        // overflow: third group dropped whole
        en = 1'b0;
        push2(64'd10, 64'd11);
        tick();
        push2(64'd12, 64'd13);
        tick();
        chk("o_full", 64'(pend), 4);
        chk("o_no_ovf", 64'(ovf), 0);
        push2(64'd14, 64'd15);
        tick();
        valid = '0;
        chk("o_pend", 64'(pend), 4);
        chk("o_ovf", 64'(ovf), 1);
        chk("o_oerr", 64'(oerr), 0);
        en = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("o_req", 64'(req), 1);
            chk("o_order", sorder, 64'(10 + i));
            ack = 1'b1;
            tick();
            ack = 1'b0;
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        chk("o_idle", 64'(idle), 1);
        chk("o_ovf_sticky", 64'(ovf), 1);
        en = 1'b0;
        push1(64'd14);
        tick();
        valid = '0;
        chk("o_exp_kept", 64'(oerr), 0);
        chk("o_pend_14", 64'(pend), 1);

        // order gap: 16 after 14
        push1(64'd16);
        tick();
        valid = '0;
        chk("g_oerr", 64'(oerr), 1);
        chk("g_pend", 64'(pend), 2);
        en = 1'b1;
        repeat (3) tick();
        chk("g_halt_req", 64'(req), 0);
        chk("g_halt_idle", 64'(idle), 0);

        // timeout
        do_reset();
        en = 1'b1;
        push1(64'd20);
        tick();
        valid = '0;
        tick();
        chk("t_req", 64'(req), 1);
        chk("t_order", sorder, 20);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (7) tick();
        chk("t_not_yet", 64'(tmo), 0);
        tick();
        chk("t_tmo", 64'(tmo), 1);
        done = 1'b1;
        push1(64'd21);
        tick();
        done = 1'b0;
        valid = '0;
        tick();
        chk("t_late_done_req", 64'(req), 0);
        chk("t_late_done_idle", 64'(idle), 0);
        chk("t_pend", 64'(pend), 1);
        chk("t_tmo_sticky", 64'(tmo), 1);

        // async reset while requesting
        do_reset();
        push2(64'd30, 64'd31);
        tick();
        push1(64'd32);
        tick();
        valid = '0;
        chk("r_pend", 64'(pend), 3);
        en = 1'b1;
        tick();
        chk("r_req", 64'(req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_req0", 64'(req), 0);
        chk("r_order0", sorder, 0);
        chk("r_pend0", 64'(pend), 0);
        chk("r_idle", 64'(idle), 1);
        chk("r_flags", {61'd0, ovf, oerr, tmo}, 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push1(64'd100);
        tick();
        valid = '0;
        chk("r_first_ok", 64'(oerr), 0);
        chk("r_first_pend", 64'(pend), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
